// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the MALU execute stage. It keeps a small
// scoreboard of the instructions in EX and MEM, produces registered
// forwarding selects for the MALU operand and syscall paths, and inserts a
// one-cycle bubble on a load-use hazard. The pipeline freezes while the
// syscall unit holds its lock.
//
// Ports
//   in_CLK, in_RST        clock, asynchronous active-high reset
//   in_ID_valid           ID stage holds a real instruction
//   in_ID_rs / in_ID_rt   ID source registers
//   in_ID_use_rs/_use_rt  ID instruction reads rs (X) / rt (Y)
//   in_ID_wr / in_ID_wreg ID instruction writes register in_ID_wreg
//   in_ID_load            ID instruction is a load (result ready at WB)
//   in_ID_syscall         ID instruction is a syscall (reads $2 and $4)
//   in_flush              squash the ID instruction (branch taken in EX)
//   in_lock               MALU syscall lock, freezes the pipeline
//   out_ALUREDI           bit0 X<-R, bit1 Y<-R, bit2 X<-WB, bit3 Y<-WB
//   out_SYSREDI           bit0 v0<-R, bit1 a0<-R, bit2 v0<-WB, bit3 a0<-WB
//   out_stall             hold PC and IF/ID this cycle
//   out_bubble            load a NOP into ID/EX this cycle
//   out_stall_cnt         saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   in_CLK,
  input  logic                   in_RST,
  input  logic                   in_ID_valid,
  input  logic [4:0]             in_ID_rs,
  input  logic [4:0]             in_ID_rt,
  input  logic                   in_ID_use_rs,
  input  logic                   in_ID_use_rt,
  input  logic                   in_ID_wr,
  input  logic [4:0]             in_ID_wreg,
  input  logic                   in_ID_load,
  input  logic                   in_ID_syscall,
  input  logic                   in_flush,
  input  logic                   in_lock,
  output logic [3:0]             out_ALUREDI,
  output logic [3:0]             out_SYSREDI,
  output logic                   out_stall,
  output logic                   out_bubble,
  output logic [STALL_CNT_W-1:0] out_stall_cnt
);

  localparam logic [4:0]             REG_V0  = 5'd2;
  localparam logic [4:0]             REG_A0  = 5'd4;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, LOCKED} state_t;

  state_t state, state_next;
  logic   freeze;

  // Scoreboard: EX slot and MEM slot
  logic       ex_valid, ex_wr, ex_load;
  logic [4:0] ex_wreg;
  logic       mem_valid, mem_wr;
  logic [4:0] mem_wreg;

  logic       lu;
  logic       enter;
  logic [3:0] alu_next, sys_next;

  // A slot produces r when it holds a valid writer of r; $0 never counts.
  function automatic logic produces(input logic v, input logic wr,
                                    input logic [4:0] wreg, input logic [4:0] r);
    return v & wr & (wreg == r) & (r != 5'd0);
  endfunction

  // Forwarding pair {WB, R}: the newer producer (EX) wins over MEM.
  function automatic logic [1:0] fwd_pair(input logic ex_hit, input logic mem_hit);
    return {~ex_hit & mem_hit, ex_hit};
  endfunction

  // FSM: state register
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) state <= RUN;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:    if (in_lock)  state_next = LOCKED;
      LOCKED: if (!in_lock) state_next = RUN;
      default:              state_next = RUN;
    endcase
  end

  // FSM: freeze output. The lock freezes from its first cycle, and the
  // cycle that leaves LOCKED already advances.
  always_comb begin
    freeze = 1'b0;
    unique case (state)
      RUN:     freeze = in_lock;
      LOCKED:  freeze = in_lock;
      default: freeze = 1'b0;
    endcase
  end

  // Hazard detection and stall/bubble priority (lock > flush > load-use)
  always_comb begin
    lu = 1'b0;
    if (in_ID_valid && ex_valid && ex_load && ex_wr && (ex_wreg != 5'd0)) begin
      lu = (in_ID_use_rs && (in_ID_rs == ex_wreg)) ||
           (in_ID_use_rt && (in_ID_rt == ex_wreg)) ||
           (in_ID_syscall && ((ex_wreg == REG_V0) || (ex_wreg == REG_A0)));
    end
    out_stall  = in_lock | (~in_flush & lu);
    out_bubble = ~in_lock & (in_flush | lu);
  end

  // Forwarding selects for the instruction about to enter EX
  always_comb begin
    logic [1:0] x, y, v0, a0;
    enter    = in_ID_valid & ~out_bubble;
    x        = fwd_pair(in_ID_use_rs & produces(ex_valid, ex_wr, ex_wreg, in_ID_rs),
                        in_ID_use_rs & produces(mem_valid, mem_wr, mem_wreg, in_ID_rs));
    y        = fwd_pair(in_ID_use_rt & produces(ex_valid, ex_wr, ex_wreg, in_ID_rt),
                        in_ID_use_rt & produces(mem_valid, mem_wr, mem_wreg, in_ID_rt));
    v0       = fwd_pair(produces(ex_valid, ex_wr, ex_wreg, REG_V0),
                        produces(mem_valid, mem_wr, mem_wreg, REG_V0));
    a0       = fwd_pair(produces(ex_valid, ex_wr, ex_wreg, REG_A0),
                        produces(mem_valid, mem_wr, mem_wreg, REG_A0));
    alu_next = 4'b0000;
    sys_next = 4'b0000;
    if (enter) begin
      alu_next = {y[1], x[1], y[0], x[0]};
      if (in_ID_syscall) sys_next = {a0[1], v0[1], a0[0], v0[0]};
    end
  end

  // ID -> EX -> MEM advance: control state (valids, selects, counter)
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      ex_valid      <= 1'b0;
      mem_valid     <= 1'b0;
      out_ALUREDI   <= 4'b0000;
      out_SYSREDI   <= 4'b0000;
      out_stall_cnt <= '0;
    end else begin
      if (!freeze) begin
        mem_valid   <= ex_valid;
        ex_valid    <= enter;
        out_ALUREDI <= alu_next;
        out_SYSREDI <= sys_next;
      end
      if (out_stall && (out_stall_cnt != CNT_MAX))
        out_stall_cnt <= out_stall_cnt + CNT_ONE;
    end
  end

  // ID -> EX -> MEM advance: slot payload, qualified by the valid bits
  always_ff @(posedge in_CLK) begin
    if (!freeze) begin
      mem_wr   <= ex_wr;
      mem_wreg <= ex_wreg;
      ex_wr    <= in_ID_wr;
      ex_wreg  <= in_ID_wreg;
      ex_load  <= in_ID_load;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl: ALU forwarding, load-use stall, syscall
// forwarding, lock freeze, flush priority, asynchronous reset and counter
// saturation (counter width reduced to 3 bits).
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wreg = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0;
  logic       id_load = 1'b0, id_syscall = 1'b0;
  logic       flush = 1'b0, lock = 1'b0;
  logic [3:0] aluredi, sysredi;
  logic       stall, bubble;
  logic [2:0] stall_cnt;

  int checks = 0;
  int passes = 0;

  hazard_ctrl #(.STALL_CNT_W(3)) dut (
    .in_CLK        (clk),
    .in_RST        (rst),
    .in_ID_valid   (id_valid),
    .in_ID_rs      (id_rs),
    .in_ID_rt      (id_rt),
    .in_ID_use_rs  (id_use_rs),
    .in_ID_use_rt  (id_use_rt),
    .in_ID_wr      (id_wr),
    .in_ID_wreg    (id_wreg),
    .in_ID_load    (id_load),
    .in_ID_syscall (id_syscall),
    .in_flush      (flush),
    .in_lock       (lock),
    .out_ALUREDI   (aluredi),
    .out_SYSREDI   (sysredi),
    .out_stall     (stall),
    .out_bubble    (bubble),
    .out_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt, input logic wr,
                    input logic [4:0] wreg, input logic ld, input logic sc);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_use_rs  = urs;
    id_use_rt  = urt;
    id_wr      = wr;
    id_wreg    = wreg;
    id_load    = ld;
    id_syscall = sc;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_stall",  stall,     1'b0);
    check("rst_bubble", bubble,    1'b0);
    check("rst_cnt",    stall_cnt, 3'd0);
    check("rst_alu",    aluredi,   4'b0000);
    check("rst_sys",    sysredi,   4'b0000);
    step();
    step();
    rst = 1'b0;
    step();

    // ALU chain back to back: add $3 ; add $5,$3,$3
    id(1, 1, 1, 1, 1, 1, 3, 0, 0);
    #1 check("chain_stall0", stall, 1'b0);
    step();
    id(1, 3, 3, 1, 1, 1, 5, 0, 0);
    #1 check("chain_stall1", stall, 1'b0);
    check("chain_bubble1", bubble, 1'b0);
    step();
    check("chain_alu_r", aluredi, 4'b0011);
    check("chain_sys",   sysredi, 4'b0000);

    // One unrelated instruction in between
    id(1, 1, 1, 1, 1, 1, 3, 0, 0);
    step();
    id(1, 10, 11, 1, 1, 1, 9, 0, 0);
    step();
    id(1, 3, 3, 1, 1, 1, 5, 0, 0);
    #1 check("gap_stall", stall, 1'b0);
    step();
    check("gap_alu_wb", aluredi, 4'b1100);

    // Both slots produce $3: the newer one (EX) wins
    id(1, 1, 1, 1, 1, 1, 3, 0, 0);
    step();
    id(1, 1, 1, 1, 1, 1, 3, 0, 0);
    step();
    id(1, 3, 3, 1, 1, 1, 5, 0, 0);
    step();
    check("newer_wins", aluredi, 4'b0011);

    // Load-use: lw $7 ; sub $8,$7,$1
    id(1, 1, 0, 1, 0, 1, 7, 1, 0);
    step();
    id(1, 7, 1, 1, 1, 1, 8, 0, 0);
    #1 check("lu_stall",  stall,  1'b1);
    check("lu_bubble", bubble, 1'b1);
    step();
    check("lu_bubble_alu", aluredi,   4'b0000);
    check("lu_cnt1",       stall_cnt, 3'd1);
    check("lu_stall_gone", stall,     1'b0);
    step();
    check("lu_alu_wb", aluredi,   4'b0100);
    check("lu_cnt2",   stall_cnt, 3'd1);

    // Syscall forwarding: addi $4 ; addi $2 ; syscall
    id(1, 0, 0, 0, 0, 1, 4, 0, 0);
    step();
    id(1, 0, 0, 0, 0, 1, 2, 0, 0);
    step();
    id(1, 2, 4, 1, 1, 0, 0, 0, 1);
    #1 check("sys_stall", stall, 1'b0);
    step();
    check("sys_sysredi", sysredi, 4'b1001);
    check("sys_aluredi", aluredi, 4'b1001);

    // Writes to $0 neither forward nor stall
    id(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    id(1, 0, 0, 0, 0, 1, 0, 1, 0);
    step();
    id(1, 0, 0, 1, 1, 1, 6, 0, 1);
    #1 check("r0_stall",  stall,  1'b0);
    check("r0_bubble", bubble, 1'b0);
    step();
    check("r0_alu", aluredi, 4'b0000);
    check("r0_sys", sysredi, 4'b0000);

    // Lock for three cycles
    id(1, 1, 1, 1, 1, 1, 3, 0, 0);
    step();
    id(1, 3, 3, 1, 1, 1, 5, 0, 0);
    step();
    check("lock_pre_alu", aluredi, 4'b0011);
    id(1, 5, 3, 1, 1, 1, 6, 0, 0);
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("lock_stall%0d", i), stall, 1'b1);
      check($sformatf("lock_bubble%0d", i), bubble, 1'b0);
      step();
      check($sformatf("lock_alu_held%0d", i), aluredi, 4'b0011);
    end
    lock = 1'b0;
    #1 check("unlock_stall", stall, 1'b0);
    step();
    check("unlock_alu", aluredi,   4'b1001);
    check("lock_cnt",   stall_cnt, 3'd4);

    // Flush beats a load-use hazard
    id(1, 0, 0, 0, 0, 1, 7, 1, 0);
    step();
    id(1, 7, 0, 1, 0, 1, 8, 0, 0);
    flush = 1'b1;
    #1 check("flush_stall",  stall,  1'b0);
    check("flush_bubble", bubble, 1'b1);
    step();
    flush = 1'b0;
    check("flush_alu", aluredi,   4'b0000);
    check("flush_cnt", stall_cnt, 3'd4);
    id(1, 8, 7, 1, 1, 1, 9, 0, 0);
    #1 check("flush_ex_empty_stall", stall, 1'b0);
    step();
    check("flush_ex_empty_alu", aluredi, 4'b1000);

    // Asynchronous reset in the middle of a stall
    id(1, 9, 0, 1, 0, 1, 1, 0, 0);
    step();
    id(1, 1, 0, 1, 0, 1, 7, 1, 0);
    step();
    check("pre_rst_alu", aluredi, 4'b0001);
    id(1, 7, 0, 1, 0, 1, 8, 0, 0);
    #1 check("pre_rst_stall", stall, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_stall",  stall,     1'b0);
    check("mid_rst_bubble", bubble,    1'b0);
    check("mid_rst_cnt",    stall_cnt, 3'd0);
    check("mid_rst_alu",    aluredi,   4'b0000);
    check("mid_rst_sys",    sysredi,   4'b0000);
    step();
    rst = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Counter saturates instead of wrapping
    lock = 1'b1;
    repeat (9) step();
    check("sat_cnt", stall_cnt, 3'd7);
    lock = 1'b0;
    step();
    check("sat_cnt_hold", stall_cnt, 3'd7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
